// File: rtl/cosine_th2_fx.sv
// cosine_th2_fx: cos(theta2) = (x^2 + y^2 - l1^2 - l2^2) / (2*l1*l2) for the SCARA IK path.
// Fixed latency: done pulses FRAC+9 edges after the accepting edge (one shared multiplier,
// restoring divider). Backpressure: none; start is only sampled while idle, ignored while busy.
//
// Ports:
//   clk_i        rising-edge clock
//   reset_n_i    asynchronous active-low reset
//   start_i      request, sampled only in IDLE
//   x_target_i   signed target x, Q(WIDTH-FRAC).FRAC
//   y_target_i   signed target y, Q(WIDTH-FRAC).FRAC
//   l1_i, l2_i   link lengths, unsigned magnitudes with FRAC fraction bits
//   busy_o       high while a computation is in flight
//   done_o       one-cycle pulse when cos_th2_o and the flags are updated
//   cos_th2_o    signed result in [-1.0, +1.0], FRAC fraction bits
//   reach_err_o  |num| > den, result saturated to +/-1.0
//   den_zero_o   l1*l2 == 0, result forced to 0

module cosine_th2_fx #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] x_target_i,
  input  logic [WIDTH-1:0] y_target_i,
  input  logic [WIDTH-1:0] l1_i,
  input  logic [WIDTH-1:0] l2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] cos_th2_o,
  output logic             reach_err_o,
  output logic             den_zero_o
);

  // Products are formed from (WIDTH+1)-bit signed operands so that the unsigned
  // link lengths square without overflow; PW holds the exact product.
  localparam int PW = 2*WIDTH + 2;
  // num/den width: three extra bits over the raw 2*WIDTH product cover the
  // four-term sum without overflow.
  localparam int NW = 2*WIDTH + 3;
  // Divider remainder carries one extra bit because it is shifted left each step.
  localparam int RW = NW + 1;
  localparam int CW = $clog2(FRAC + 1);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_SUM,
    S_CHECK,
    S_DIV,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [2:0]       idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] x_q,  x_d;
  logic [WIDTH-1:0] y_q,  y_d;
  logic [WIDTH-1:0] l1_q, l1_d;
  logic [WIDTH-1:0] l2_q, l2_d;

  logic [PW-1:0]    xx_q,   xx_d;
  logic [PW-1:0]    yy_q,   yy_d;
  logic [PW-1:0]    l1l1_q, l1l1_d;
  logic [PW-1:0]    l2l2_q, l2l2_d;
  logic [PW-1:0]    l1l2_q, l1l2_d;

  logic [NW-1:0]    num_q, num_d;
  logic [NW-1:0]    den_q, den_d;

  logic [RW-1:0]    rem_q, rem_d;
  logic [FRAC:0]    quo_q, quo_d;
  logic             sgn_q, sgn_d;
  logic             dz_q,  dz_d;
  logic             rch_q, rch_d;

  logic [WIDTH-1:0] cos_q,   cos_d;
  logic             reach_q, reach_d;
  logic             denz_q,  denz_d;
  logic             done_q,  done_d;
  logic             busy_q,  busy_d;

  // ---------------------------------------------------------------------------
  // Operand extension helpers
  // ---------------------------------------------------------------------------
  function automatic logic [PW-1:0] sext_op(input logic [WIDTH-1:0] v);
    return {{(PW-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  function automatic logic [PW-1:0] zext_op(input logic [WIDTH-1:0] v);
    return {{(PW-WIDTH){1'b0}}, v};
  endfunction

  function automatic logic [NW-1:0] sext_p(input logic [PW-1:0] p);
    return {p[PW-1], p};
  endfunction

  // ---------------------------------------------------------------------------
  // Shared multiplier. Operands are extended to the full product width, so the
  // truncated product equals the exact two's complement product.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] mul_a, mul_b, mul_p;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (idx_q)
      3'd0: begin
        mul_a = sext_op(x_q);
        mul_b = sext_op(x_q);
      end
      3'd1: begin
        mul_a = sext_op(y_q);
        mul_b = sext_op(y_q);
      end
      3'd2: begin
        mul_a = zext_op(l1_q);
        mul_b = zext_op(l1_q);
      end
      3'd3: begin
        mul_a = zext_op(l2_q);
        mul_b = zext_op(l2_q);
      end
      default: begin
        mul_a = zext_op(l1_q);
        mul_b = zext_op(l2_q);
      end
    endcase
  end

  assign mul_p = mul_a * mul_b;

  // ---------------------------------------------------------------------------
  // Magnitude of the numerator and one restoring-division step
  // ---------------------------------------------------------------------------
  logic [NW-1:0] abs_num;
  logic [RW-1:0] den_ext;
  logic          div_ge;
  logic [RW-1:0] div_rem;

  assign abs_num = num_q[NW-1] ? -num_q : num_q;
  assign den_ext = {1'b0, den_q};
  assign div_ge  = (rem_q >= den_ext);
  assign div_rem = div_ge ? (rem_q - den_ext) : rem_q;

  // Result magnitude for the in-range case; quotient never exceeds 1.0 there.
  logic [WIDTH-1:0] q_ext;
  assign q_ext = {{(WIDTH-FRAC-1){1'b0}}, quo_q};

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    l1_d    = l1_q;
    l2_d    = l2_q;
    xx_d    = xx_q;
    yy_d    = yy_q;
    l1l1_d  = l1l1_q;
    l2l2_d  = l2l2_q;
    l1l2_d  = l1l2_q;
    num_d   = num_q;
    den_d   = den_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    sgn_d   = sgn_q;
    dz_d    = dz_q;
    rch_d   = rch_q;
    cos_d   = cos_q;
    reach_d = reach_q;
    denz_d  = denz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          x_d     = x_target_i;
          y_d     = y_target_i;
          l1_d    = l1_i;
          l2_d    = l2_i;
          idx_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = S_MUL;
        end
      end

      S_MUL: begin
        case (idx_q)
          3'd0:    xx_d   = mul_p;
          3'd1:    yy_d   = mul_p;
          3'd2:    l1l1_d = mul_p;
          3'd3:    l2l2_d = mul_p;
          default: l1l2_d = mul_p;
        endcase
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd4) begin
          state_d = S_SUM;
        end
      end

      S_SUM: begin
        num_d   = sext_p(xx_q) + sext_p(yy_q) - sext_p(l1l1_q) - sext_p(l2l2_q);
        den_d   = {l1l2_q, 1'b0};
        state_d = S_CHECK;
      end

      S_CHECK: begin
        dz_d    = (den_q == '0);
        rch_d   = (abs_num > den_q);
        sgn_d   = num_q[NW-1];
        // Shifting the remainder each step instead of pre-shifting the
        // dividend by FRAC yields the same floor(|num|*2^FRAC/den).
        rem_d   = {1'b0, abs_num};
        cnt_d   = '0;
        state_d = S_DIV;
      end

      S_DIV: begin
        // First step produces the integer bit, the remaining FRAC steps the
        // fraction bits. Runs to completion even when a flag is set so the
        // latency never varies.
        quo_d = {quo_q[FRAC-1:0], div_ge};
        rem_d = div_rem << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(FRAC)) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        if (dz_q) begin
          cos_d   = '0;
          denz_d  = 1'b1;
          reach_d = 1'b0;
        end else if (rch_q) begin
          cos_d   = sgn_q ? -ONE : ONE;
          denz_d  = 1'b0;
          reach_d = 1'b1;
        end else begin
          // A zero quotient negates to zero, so no negative zero appears.
          cos_d   = sgn_q ? -q_ext : q_ext;
          denz_d  = 1'b0;
          reach_d = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      l1_q    <= '0;
      l2_q    <= '0;
      xx_q    <= '0;
      yy_q    <= '0;
      l1l1_q  <= '0;
      l2l2_q  <= '0;
      l1l2_q  <= '0;
      num_q   <= '0;
      den_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      sgn_q   <= 1'b0;
      dz_q    <= 1'b0;
      rch_q   <= 1'b0;
      cos_q   <= '0;
      reach_q <= 1'b0;
      denz_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      l1_q    <= l1_d;
      l2_q    <= l2_d;
      xx_q    <= xx_d;
      yy_q    <= yy_d;
      l1l1_q  <= l1l1_d;
      l2l2_q  <= l2l2_d;
      l1l2_q  <= l1l2_d;
      num_q   <= num_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      sgn_q   <= sgn_d;
      dz_q    <= dz_d;
      rch_q   <= rch_d;
      cos_q   <= cos_d;
      reach_q <= reach_d;
      denz_q  <= denz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign cos_th2_o   = cos_q;
  assign reach_err_o = reach_q;
  assign den_zero_o  = denz_q;

endmodule

// File: tb/tb_cosine_th2_fx.sv
// tb_cosine_th2_fx: self-checking bench for cosine_th2_fx (WIDTH=32, FRAC=16).
// Latency: expects done 25 edges after the accepting edge.
// Backpressure: exercises start held high while busy and reset during a run.

module tb_cosine_th2_fx;

  localparam int LAT = 25;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] x, y, l1, l2;
  logic        busy, done, reach_err, den_zero;
  logic [31:0] cos_th2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cosine_th2_fx #(.WIDTH(32), .FRAC(16)) dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .start_i     (start),
    .x_target_i  (x),
    .y_target_i  (y),
    .l1_i        (l1),
    .l2_i        (l2),
    .busy_o      (busy),
    .done_o      (done),
    .cos_th2_o   (cos_th2),
    .reach_err_o (reach_err),
    .den_zero_o  (den_zero)
  );

  // Reference: exact wide-integer arithmetic straight from the formula.
  function automatic void model(input logic [31:0] xi, input logic [31:0] yi,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] c, output logic re, output logic dz);
    logic signed [127:0] sx, sy, la, lb, num, den, mag, q;
    sx  = {{96{xi[31]}}, xi};
    sy  = {{96{yi[31]}}, yi};
    la  = {96'b0, a};
    lb  = {96'b0, b};
    num = sx*sx + sy*sy - la*la - lb*lb;
    den = (la*lb) <<< 1;
    mag = (num < 0) ? -num : num;
    re  = 1'b0;
    dz  = 1'b0;
    if (den == 0) begin
      c  = 32'h0;
      dz = 1'b1;
    end else if (mag > den) begin
      re = 1'b1;
      c  = (num < 0) ? 32'hFFFF0000 : 32'h00010000;
    end else begin
      q = (mag <<< 16) / den;
      c = (num < 0) ? -q[31:0] : q[31:0];
    end
  endfunction

  // Drive one request and return the number of edges until done (bounded).
  task automatic run_op(input logic [31:0] xi, input logic [31:0] yi,
                        input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    x = xi; y = yi; l1 = a; l2 = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    x = 32'h00020000; y = 32'h0; l1 = 32'h00010000; l2 = 32'h00010000;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (cos_th2 !== 32'h0) begin failures++; $display("FAIL reset_cos got=%h exp=00000000", cos_th2); end
    checks++; if (reach_err !== 1'b0) begin failures++; $display("FAIL reset_reach got=%b exp=0", reach_err); end
    checks++; if (den_zero !== 1'b0) begin failures++; $display("FAIL reset_denz got=%b exp=0", den_zero); end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle busy got=%b exp=0", busy); end
  endtask

  typedef struct {
    logic [31:0] x, y, a, b, c;
    logic        re, dz;
  } vec_t;

  task automatic test_directed;
    vec_t v[9];
    int   lat;
    v[0] = '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0, 1'b0};
    v[1] = '{32'h00020000, 32'h00000000, 32'h00010000, 32'h00010000, 32'h00010000, 1'b0, 1'b0};
    v[2] = '{32'h00000000, 32'h00000000, 32'h00010000, 32'h00010000, 32'hFFFF0000, 1'b0, 1'b0};
    v[3] = '{32'h00010000, 32'h00000000, 32'h00010000, 32'h00010000, 32'hFFFF8000, 1'b0, 1'b0};
    v[4] = '{32'h00018000, 32'h00000000, 32'h00010000, 32'h00010000, 32'h00002000, 1'b0, 1'b0};
    v[5] = '{32'h00030000, 32'h00000000, 32'h00010000, 32'h00010000, 32'h00010000, 1'b1, 1'b0};
    v[6] = '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
    v[7] = '{32'hFFFF0000, 32'h00000000, 32'h00010000, 32'h00010000, 32'hFFFF8000, 1'b0, 1'b0};
    v[8] = '{32'h00030000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      run_op(v[i].x, v[i].y, v[i].a, v[i].b, lat);
      checks++; if (lat != LAT) begin failures++; $display("FAIL dir[%0d] latency got=%0d exp=%0d", i, lat, LAT); end
      checks++; if (cos_th2 !== v[i].c) begin failures++; $display("FAIL dir[%0d] cos got=%h exp=%h", i, cos_th2, v[i].c); end
      checks++; if (reach_err !== v[i].re) begin failures++; $display("FAIL dir[%0d] reach got=%b exp=%b", i, reach_err, v[i].re); end
      checks++; if (den_zero !== v[i].dz) begin failures++; $display("FAIL dir[%0d] denz got=%b exp=%b", i, den_zero, v[i].dz); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dir[%0d] busy_at_done got=%b exp=0", i, busy); end
    end
  endtask

  task automatic test_random;
    logic [31:0] rx, ry, ra, rb, ec;
    logic        ere, edz;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        rx = $urandom; ry = $urandom; ra = $urandom; rb = $urandom;
      end else begin
        rx = 32'($urandom_range(0, 32'h00080000)) - 32'h00040000;
        ry = 32'($urandom_range(0, 32'h00080000)) - 32'h00040000;
        ra = $urandom_range(0, 32'h00030000);
        rb = $urandom_range(0, 32'h00030000);
        if ($urandom_range(0, 9) == 0) rb = 32'h0;
      end
      model(rx, ry, ra, rb, ec, ere, edz);
      run_op(rx, ry, ra, rb, lat);
      checks++; if (lat != LAT) begin failures++; $display("FAIL rand[%0d] latency got=%0d exp=%0d", i, lat, LAT); end
      checks++; if (cos_th2 !== ec) begin failures++; $display("FAIL rand[%0d] cos x=%h y=%h l1=%h l2=%h got=%h exp=%h", i, rx, ry, ra, rb, cos_th2, ec); end
      checks++; if (reach_err !== ere) begin failures++; $display("FAIL rand[%0d] reach got=%b exp=%b", i, reach_err, ere); end
      checks++; if (den_zero !== edz) begin failures++; $display("FAIL rand[%0d] denz got=%b exp=%b", i, den_zero, edz); end
    end
  endtask

  task automatic test_hold;
    logic [31:0] ec;
    logic        ere, edz;
    int          lat;
    model(32'h00018000, 32'h0, 32'h00010000, 32'h00010000, ec, ere, edz);
    run_op(32'h00018000, 32'h0, 32'h00010000, 32'h00010000, lat);
    @(negedge clk);
    x = 32'h00030000; l2 = 32'h0;
    repeat (12) @(posedge clk);
    #1;
    checks++; if (cos_th2 !== ec) begin failures++; $display("FAIL hold_cos got=%h exp=%h", cos_th2, ec); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL hold_done got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_busy got=%b exp=0", busy); end
    checks++; if (reach_err !== 1'b0 || den_zero !== 1'b0) begin failures++; $display("FAIL hold_flags got=%b%b exp=00", reach_err, den_zero); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ca, cb;
    logic        rea, dza, reb, dzb;
    int          lat;
    model(32'h00018000, 32'h00000000, 32'h00010000, 32'h00010000, ca, rea, dza);
    model(32'h00010000, 32'h00000000, 32'h00010000, 32'h00010000, cb, reb, dzb);
    @(negedge clk);
    x = 32'h00018000; y = 32'h0; l1 = 32'h00010000; l2 = 32'h00010000;
    start = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_after_accept got=%b exp=1", busy); end
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) x = 32'h00010000;
    end
    checks++; if (lat != LAT) begin failures++; $display("FAIL b2b_lat1 got=%0d exp=%0d", lat, LAT); end
    checks++; if (cos_th2 !== ca) begin failures++; $display("FAIL b2b_cos1 got=%h exp=%h", cos_th2, ca); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_at_done got=%b exp=0", busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_second_accept busy got=%b exp=1", busy); end
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != LAT) begin failures++; $display("FAIL b2b_lat2 got=%0d exp=%0d", lat, LAT); end
    checks++; if (cos_th2 !== cb) begin failures++; $display("FAIL b2b_cos2 got=%h exp=%h", cos_th2, cb); end
  endtask

  task automatic test_reset_midop;
    int lat;
    int pulses;
    run_op(32'h00020000, 32'h0, 32'h00010000, 32'h00010000, lat);
    @(negedge clk);
    x = 32'h00030000; y = 32'h0; l1 = 32'h00010000; l2 = 32'h00010000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (cos_th2 !== 32'h0) begin failures++; $display("FAIL midrst_cos got=%h exp=00000000", cos_th2); end
    checks++; if (reach_err !== 1'b0 || den_zero !== 1'b0) begin failures++; $display("FAIL midrst_flags got=%b%b exp=00", reach_err, den_zero); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL midrst_no_done got=%0d pulses exp=0", pulses); end
    run_op(32'h00010000, 32'h0, 32'h00010000, 32'h00010000, lat);
    checks++; if (lat != LAT) begin failures++; $display("FAIL midrst_restart_lat got=%0d exp=%0d", lat, LAT); end
    checks++; if (cos_th2 !== 32'hFFFF8000) begin failures++; $display("FAIL midrst_restart_cos got=%h exp=ffff8000", cos_th2); end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    x = '0; y = '0; l1 = '0; l2 = '0;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
